// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit. A Moore FSM walks each instruction through
// fetch, decode and execute steps. It drives the datapath mux selects, the
// write enables and the memory handshake, and counts retired instructions.
module mips_multicycle_control (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        trap,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    ST_INIT      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_ADDI_EXEC = 4'd11,
    ST_ADDI_WB   = 4'd12,
    ST_TRAP      = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALU operand B selects
  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_IMMSH = 2'b11;

  // ALU operation selects
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // PC source selects
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  state_e      state_q, state_d;
  // armed_q holds INIT for one full cycle after reset release, so the first
  // FETCH starts on the second rising edge.
  logic        armed_q, armed_d;
  logic [31:0] count_q, count_d;
  logic        retire;

  // State, arming flag and retired-instruction counter registers
  // NOTE: non-blocking assignments make every flop sample pre-edge values, so
  // the order of statements in sequential blocks never matters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      armed_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      count_q <= count_d;
    end
  end

  // Next-state logic and Moore outputs, plus the FETCH/BRANCH input-gated enables
  // NOTE: every output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    armed_d    = 1'b1;
    retire     = 1'b0;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    alu_op     = ALU_ADD;
    pc_source  = PC_ALU;
    trap       = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (armed_q) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        // PC+4 goes straight back to the PC while the instruction is latched.
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end

      ST_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = SRC_B_IMMSH;
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_RTYPE:     state_d = ST_R_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDI_EXEC;
          default:      state_d = ST_TRAP;
        endcase
      end

      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_LW:   state_d = ST_MEM_READ;
          OP_SW:   state_d = ST_MEM_WRITE;
          default: state_d = ST_TRAP;
        endcase
      end

      ST_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = ST_MEM_WB;
      end

      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = ST_R_WB;
      end

      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end

      ST_BRANCH: begin
        // A not-taken branch still retires.
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PC_ALUOUT;
        pc_en     = zero;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end

      ST_JUMP: begin
        pc_source = PC_JUMP;
        pc_en     = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end

      ST_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        state_d   = ST_ADDI_WB;
      end

      ST_ADDI_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end

      ST_TRAP: begin
        // Sticky until reset.
        trap = 1'b1;
      end

      default: begin
        // Unused encodings 14 and 15 recover into TRAP.
        state_d = ST_TRAP;
      end
    endcase
  end

  // Retired-instruction counter, wrapping naturally at 2^32
  always_comb begin
    count_d = count_q;
    if (retire) count_d = count_q + 32'd1;
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule
